// File: rtl/ser_pkg.sv
// ser_pkg: shared constants, state encoding and timing helper for the ser transmitter/receiver pair.
// Rev 1.0
`default_nettype none

package ser_pkg;

  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD   = 2000;
  localparam int CNT_W      = 32;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_t;

  // Clocks per bit; callers must keep the result >= 2.
  function automatic int bit_clocks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser_baud_cnt.sv
// ser_baud_cnt: loadable down-counter that holds at zero and flags zero as a one-cycle tick.
// Rev 1.0
`default_nettype none

module ser_baud_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // Loading N-1 on a boundary yields a tick after exactly N cycles.
  assign tick = (count == '0);

endmodule

`default_nettype wire

// File: rtl/ser_xmt.sv
// ser_xmt: 8N1 LSB-first serial transmitter with a one-byte holding register for gapless frames.
// Rev 1.0
`default_nettype none

module ser_xmt
  import ser_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int BIT_CLOCKS = bit_clocks(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] parallel_in,
  output logic       ready,
  output logic       busy,
  output logic       serial_out
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CLOCKS - 1);

  ser_state_t state, state_nxt;

  logic [7:0] hold_data;
  logic       hold_full;
  logic [7:0] shreg, shreg_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic       line_nxt;
  logic       take;
  logic       cnt_load;
  logic       tick;
  logic       accept;

  assign accept = wr & ~hold_full;
  assign ready  = ~hold_full;
  assign busy   = (state != IDLE);

  ser_baud_cnt #(
    .WIDTH(CNT_W)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .load    (cnt_load),
    .load_val(RELOAD),
    .tick    (tick)
  );

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    line_nxt    = serial_out;
    take        = 1'b0;
    cnt_load    = 1'b0;
    case (state)
      IDLE: begin
        line_nxt = IDLE_LEVEL;
        if (hold_full) begin
          take      = 1'b1;
          cnt_load  = 1'b1;
          shreg_nxt = hold_data;
          line_nxt  = START_LEVEL;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_load    = 1'b1;
          bit_idx_nxt = 3'd0;
          line_nxt    = shreg[0];
          shreg_nxt   = shreg >> 1;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_load = 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            line_nxt  = STOP_LEVEL;
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            line_nxt    = shreg[0];
            shreg_nxt   = shreg >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          // A byte already queued before this edge chains straight into the next start bit.
          if (hold_full) begin
            take      = 1'b1;
            cnt_load  = 1'b1;
            shreg_nxt = hold_data;
            line_nxt  = START_LEVEL;
            state_nxt = START;
          end else begin
            line_nxt  = IDLE_LEVEL;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        line_nxt  = IDLE_LEVEL;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      serial_out <= IDLE_LEVEL;
      shreg      <= '0;
      bit_idx    <= '0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
    end else begin
      state      <= state_nxt;
      serial_out <= line_nxt;
      shreg      <= shreg_nxt;
      bit_idx    <= bit_idx_nxt;
      if (take) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold_data <= parallel_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ser_xmt.sv
// tb_ser_xmt: self-checking bench for ser_xmt against a frame-level line model.
// Rev 1.0
`default_nettype none

module tb_ser_xmt;

  localparam int BC = 16;
  localparam int FRAME = 10 * BC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] parallel_in = 8'h00;
  logic       ready;
  logic       busy;
  logic       serial_out;

  int checks = 0;
  int failures = 0;

  ser_xmt #(
    .CLK_HZ(16),
    .BAUD  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .parallel_in(parallel_in),
    .ready      (ready),
    .busy       (busy),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  // 8N1 frame as it appears on the line, bit 0 first.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Called at a negedge; the accepting edge is the next posedge; returns at the negedge after it.
  task automatic write_byte(input logic [7:0] b);
    wr = 1'b1;
    parallel_in = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (serial_out !== 1'b1) begin failures++; $display("FAIL reset_line: serial_out=%b expected=1", serial_out); end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: ready=%b expected=1", ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: busy=%b expected=0", busy); end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== 1'b1) begin failures++; $display("FAIL idle_line cyc%0d: serial_out=%b expected=1", i, serial_out); end
    end
  endtask

  task automatic test_single();
    logic [9:0] f;
    f = frame_of(8'hA5);
    write_byte(8'hA5);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL single_ready_accept: ready=%b expected=0", ready); end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL single_ready_load: ready=%b expected=1", ready); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: busy=%b expected=1", busy); end
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (serial_out !== f[i / BC]) begin
        failures++;
        $display("FAIL single_line cyc%0d: serial_out=%b expected=%b", i, serial_out, f[i / BC]);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: busy=%b expected=0", busy); end
    checks++;
    if (serial_out !== 1'b1) begin failures++; $display("FAIL single_line_end: serial_out=%b expected=1", serial_out); end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
    logic [9:0] f0, f1;
    f0 = frame_of(b0);
    f1 = frame_of(b1);
    write_byte(b0);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 2 * FRAME; i++) begin
          logic exp;
          exp = (i < FRAME) ? f0[i / BC] : f1[(i - FRAME) / BC];
          checks++;
          if (serial_out !== exp) begin
            failures++;
            $display("FAIL b2b_line cyc%0d: serial_out=%b expected=%b", i, serial_out, exp);
          end
          @(negedge clk);
        end
      end
      begin
        repeat (40) @(negedge clk);
        write_byte(b1);
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_queued: ready=%b expected=0", ready); end
      end
    join
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end: busy=%b expected=0", busy); end
  endtask

  task automatic test_ignored_write();
    logic [7:0] r;
    logic [9:0] f0, f1;
    r = 8'($urandom);
    f0 = frame_of(8'h55);
    f1 = frame_of(r);
    write_byte(8'h55);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 2 * FRAME; i++) begin
          logic exp;
          exp = (i < FRAME) ? f0[i / BC] : f1[(i - FRAME) / BC];
          checks++;
          if (serial_out !== exp) begin
            failures++;
            $display("FAIL ignored_line cyc%0d: serial_out=%b expected=%b", i, serial_out, exp);
          end
          @(negedge clk);
        end
        for (int i = 0; i < 40; i++) begin
          checks++;
          if (serial_out !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_idle cyc%0d: serial_out=%b busy=%b expected=1/0", i, serial_out, busy);
          end
          @(negedge clk);
        end
      end
      begin
        repeat (20) @(negedge clk);
        write_byte(r);
        repeat (10) @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL ignored_ready: ready=%b expected=0", ready); end
        write_byte(8'h33);
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] f;
    write_byte(8'h0F);
    @(negedge clk);
    repeat (70) @(negedge clk);
    checks++;
    if (serial_out !== 1'b1) begin failures++; $display("FAIL midreset_d3: serial_out=%b expected=1", serial_out); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_pre: busy=%b expected=1", busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (serial_out !== 1'b1) begin failures++; $display("FAIL midreset_line: serial_out=%b expected=1", serial_out); end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL midreset_ready: ready=%b expected=1", ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: busy=%b expected=0", busy); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    f = frame_of(8'h81);
    write_byte(8'h81);
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (serial_out !== f[i / BC]) begin
        failures++;
        $display("FAIL midreset_after cyc%0d: serial_out=%b expected=%b", i, serial_out, f[i / BC]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stop_edge_write();
    logic [7:0] b0, b1;
    logic [9:0] f0, f1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    f0 = frame_of(b0);
    f1 = frame_of(b1);
    write_byte(b0);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < FRAME; i++) begin
          checks++;
          if (serial_out !== f0[i / BC]) begin
            failures++;
            $display("FAIL stopedge_f0 cyc%0d: serial_out=%b expected=%b", i, serial_out, f0[i / BC]);
          end
          @(negedge clk);
        end
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL stopedge_gap: serial_out=%b busy=%b expected=1/0", serial_out, busy);
        end
        @(negedge clk);
        for (int i = 0; i < FRAME; i++) begin
          checks++;
          if (serial_out !== f1[i / BC]) begin
            failures++;
            $display("FAIL stopedge_f1 cyc%0d: serial_out=%b expected=%b", i, serial_out, f1[i / BC]);
          end
          @(negedge clk);
        end
      end
      begin
        repeat (FRAME - 1) @(negedge clk);
        write_byte(b1);
      end
    join
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int n;
          logic [7:0] b;
          repeat ($urandom_range(0, 200)) @(negedge clk);
          n = 0;
          while (ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
          end
          b = 8'($urandom);
          q.push_back(b);
          write_byte(b);
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          int n;
          logic [7:0] b;
          logic [9:0] f;
          n = 0;
          while (serial_out !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
          end
          checks++;
          if (n >= 2000 || q.size() == 0) begin
            failures++;
            $display("FAIL random_start frame%0d: waited=%0d queued=%0d expected start bit", k, n, q.size());
            break;
          end
          b = q.pop_front();
          f = frame_of(b);
          for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (serial_out !== f[i / BC]) begin
              failures++;
              $display("FAIL random_line frame%0d byte=%h cyc%0d: serial_out=%b expected=%b", k, b, i, serial_out, f[i / BC]);
            end
            @(negedge clk);
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back(8'h00, 8'hFF);
    test_ignored_write();
    test_reset_mid_frame();
    test_stop_edge_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
